ex_operand_stage: RTL

- Decode-to-execute pipeline register that directly feeds the ALU. Captures decoded instructions through a valid/ready handshake.
- Resolves RAW hazards at capture by forwarding from the ALU result and the writeback bus. Inserts one bubble on a load-use hazard.
- Drives the ALU A, B and ALUControl inputs from registered state, so ALU inputs are glitch-free for the whole cycle.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fwd_mux.sv | 30 +++
 rtl/ex_operand_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 datapath constants: widths, ALU opcodes and result-source encodings
// used by the execute-stage operand logic.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10
    } result_src_e;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand selector: the in-flight EX result beats the writeback bus,
// which beats the register file. x0 is never forwarded.
module fwd_mux #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic [REGW-1:0] src,
    input  logic [XLEN-1:0] id_data,
    input  logic            ex_en,
    input  logic [REGW-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_en,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        // NOTE: assign a default first so every path drives data and no latch is inferred.
        data = id_data;
        if (src != '0) begin
            if (ex_en && (ex_rd == src)) begin
                data = ex_data;
            end else if (wb_en && (wb_rd == src)) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register feeding the ALU from registered state,
// with operand forwarding resolved at capture and a one-bubble load-use stall.
module ex_operand_stage #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int REGW = riscv_pkg::REGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_alu_src,
    input  logic [2:0]      id_alu_control,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic [1:0]      id_result_src,
    input  logic [XLEN-1:0] alu_result,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [2:0]      ex_alu_control,
    output logic [XLEN-1:0] ex_rs2_fwd,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic [1:0]      ex_result_src
);

    import riscv_pkg::*;

    logic            ex_fwd_en;
    logic [XLEN-1:0] ex_fwd_data;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;
    logic            capture;

    // A held load has no value yet; its data arrives later over the writeback bus.
    assign ex_fwd_en   = ex_valid && ex_reg_write && (ex_result_src != RS_LOAD);
    assign ex_fwd_data = (ex_result_src == RS_PC4) ? (ex_pc + XLEN'(4)) : alu_result;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .src     (id_rs1),
        .id_data (id_rs1_data),
        .ex_en   (ex_fwd_en),
        .ex_rd   (ex_rd),
        .ex_data (ex_fwd_data),
        .wb_en   (wb_valid),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .data    (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .src     (id_rs2),
        .id_data (id_rs2_data),
        .ex_en   (ex_fwd_en),
        .ex_rd   (ex_rd),
        .ex_data (ex_fwd_data),
        .wb_en   (wb_valid),
        .wb_rd   (wb_rd),
        .wb_data (wb_data),
        .data    (fwd_rs2)
    );

    assign load_use = id_valid && ex_valid && (ex_result_src == RS_LOAD) && ex_reg_write
                      && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign id_ready = rst && (!ex_valid || ex_ready) && !load_use && !flush;
    assign capture  = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            ex_valid       <= 1'b0;
            ex_a           <= '0;
            ex_b           <= '0;
            ex_alu_control <= '0;
            ex_rs2_fwd     <= '0;
            ex_pc          <= '0;
            ex_rd          <= '0;
            ex_reg_write   <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_result_src  <= '0;
        end else if (flush) begin
            // Only the side-effect bits are cleared; stale data is harmless once invalid.
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (capture) begin
            ex_valid       <= 1'b1;
            ex_a           <= fwd_rs1;
            ex_b           <= id_alu_src ? id_imm : fwd_rs2;
            ex_alu_control <= id_alu_control;
            ex_rs2_fwd     <= fwd_rs2;
            ex_pc          <= id_pc;
            ex_rd          <= id_rd;
            ex_reg_write   <= id_reg_write;
            ex_mem_write   <= id_mem_write;
            ex_result_src  <= id_result_src;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
